// File: rtl/gcd_unit.sv
// gcd_unit: iterative greatest-common-divisor engine.
// MODE=0 reduces by subtraction (Euclid). MODE=1 uses binary reduction
// (Stein), in which common factors of two are stripped and counted in k.
// One reduction step is performed per clock while busy.
module gcd_unit #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int ITW   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             go,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic [ITW-1:0]   iter,
    output logic             zerr
);

    // k only has to reach WIDTH-1, the largest power of two that can
    // divide two nonzero WIDTH-bit operands.
    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0]  K_MAX    = KW'(WIDTH - 1);
    localparam logic [ITW-1:0] STEP_MAX = {ITW{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [KW-1:0]    k_q, k_d;
    logic [ITW-1:0]   step_q, step_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [ITW-1:0]   iter_q, iter_d;
    logic             zerr_q, zerr_d;

    // One reduction step of the selected algorithm, used on any RUN cycle
    // that does not finish.
    logic [WIDTH-1:0] red_x;
    logic [WIDTH-1:0] red_y;
    logic             red_k;

    generate
        if (MODE == 1) begin : g_stein
            // Binary reduction: halve even operands first, subtract only
            // when both are odd, and always from the larger one.
            always_comb begin
                red_x = x_q;
                red_y = y_q;
                red_k = 1'b0;
                if (!x_q[0] && !y_q[0]) begin
                    red_x = x_q >> 1;
                    red_y = y_q >> 1;
                    red_k = 1'b1;
                end else if (!x_q[0]) begin
                    red_x = x_q >> 1;
                end else if (!y_q[0]) begin
                    red_y = y_q >> 1;
                end else if (x_q < y_q) begin
                    red_y = y_q - x_q;
                end else begin
                    red_x = x_q - y_q;
                end
            end
        end else begin : g_euclid
            // Subtractive reduction: take the smaller operand from the larger.
            always_comb begin
                red_x = x_q;
                red_y = y_q;
                red_k = 1'b0;
                if (x_q < y_q) begin
                    red_y = y_q - x_q;
                end else begin
                    red_x = x_q - y_q;
                end
            end
        end
    endgenerate

    // Termination tests evaluated at the start of every RUN cycle.
    logic fin_zero;
    logic fin_equal;
    assign fin_zero  = (x_q == '0) || (y_q == '0);
    assign fin_equal = (x_q == y_q);

    // Next-state and datapath control; results only move on a finishing cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        step_d  = step_q;
        done_d  = 1'b0;
        gcd_d   = gcd_q;
        iter_d  = iter_q;
        zerr_d  = zerr_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    x_d     = xin;
                    y_d     = yin;
                    k_d     = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fin_zero) begin
                    gcd_d   = x_q | y_q;
                    zerr_d  = (x_q == '0) && (y_q == '0);
                    iter_d  = step_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (fin_equal) begin
                    // k stays 0 in subtractive mode, so the shift is a no-op there.
                    gcd_d   = x_q << k_q;
                    zerr_d  = 1'b0;
                    iter_d  = step_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d = red_x;
                    y_d = red_y;
                    if (red_k && (k_q != K_MAX)) begin
                        k_d = k_q + 1'b1;
                    end
                    if (step_q != STEP_MAX) begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous clear; clear wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
            gcd_q   <= '0;
            iter_q  <= '0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            step_q  <= step_d;
            done_q  <= done_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
            zerr_q  <= zerr_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign gcd  = gcd_q;
    assign iter = iter_q;
    assign zerr = zerr_q;

endmodule
